// File: rtl/sync_arith_unit.sv
// rtl/sync_arith_unit.sv - registered four-op signed arithmetic unit with status flags
module sync_arith_unit #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    input  logic [N-1:0] i_op,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam logic [M-1:0] WIDTH_M = M'(M);

    logic [M+1:0] diff;
    logic         dbl_ovf;
    logic         diff_ovf;
    logic [M-1:0] one_hot;
    logic [M-2:0] mag;
    logic         a_is_min;

    logic [M-1:0] res;
    logic         err;
    logic         ovf;

    // A - 2B at M+2 bits; 2B itself only fits in M bits when B's top two bits agree
    assign diff     = {{2{i_arg_A[M-1]}}, i_arg_A} - {i_arg_B[M-1], i_arg_B, 1'b0};
    assign dbl_ovf  = i_arg_B[M-1] ^ i_arg_B[M-2];
    assign diff_ovf = !((diff[M+1] == diff[M]) && (diff[M] == diff[M-1]));

    assign one_hot  = M'(1) << i_arg_B;
    assign mag      = (~i_arg_A[M-2:0]) + (M-1)'(1);
    assign a_is_min = i_arg_A[M-1] && !(|i_arg_A[M-2:0]);

    always_comb begin
        res = '0;
        err = 1'b0;
        ovf = 1'b0;
        case (i_op[1:0])
            2'b00: begin
                if (dbl_ovf || diff_ovf) begin
                    err = 1'b1;
                    ovf = 1'b1;
                end else begin
                    res = diff[M-1:0];
                end
            end
            2'b01: begin
                res = {{(M-1){1'b0}}, ($signed(i_arg_A) < $signed(i_arg_B))};
            end
            2'b10: begin
                if (i_arg_B < WIDTH_M) res = i_arg_A & ~one_hot;
                else                   err = 1'b1;
            end
            default: begin
                if (a_is_min)          err = 1'b1;
                else if (i_arg_A[M-1]) res = {1'b1, mag};
                else                   res = i_arg_A;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_result <= '0;
            o_status <= 4'b0000;
        end else begin
            o_result <= res;
            o_status <= {&res, ^res, ovf, err};
        end
    end

endmodule

// File: tb/tb_sync_arith_unit.sv
// tb/tb_sync_arith_unit.sv - directed vector bench for sync_arith_unit
module tb_sync_arith_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] arg_a = '0;
    logic [3:0] arg_b = '0;
    logic [1:0] op = '0;
    logic [3:0] result;
    logic [3:0] status;

    int checks = 0;
    int errors = 0;

    sync_arith_unit #(.N(2), .M(4)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_arg_A  (arg_a),
        .i_arg_B  (arg_b),
        .i_op     (op),
        .o_result (result),
        .o_status (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp_r, input logic [3:0] exp_s);
        checks++;
        assert ({result, status} === {exp_r, exp_s})
        else begin
            errors++;
            $error("FAIL %s: result=%b status=%b expected result=%b status=%b",
                   tag, result, status, exp_r, exp_s);
        end
    endtask

    task automatic apply(input string tag, input logic [1:0] o, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp_r, input logic [3:0] exp_s);
        @(negedge clk);
        op    = o;
        arg_a = a;
        arg_b = b;
        @(posedge clk);
        #1;
        check(tag, exp_r, exp_s);
    endtask

    initial begin
        op    = 2'b01;
        arg_a = 4'd1;
        arg_b = 4'd5;
        @(posedge clk);
        #1;
        check("reset_hold", 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", 4'b0000, 4'b0000);

        apply("sub_3_1",      2'b00, 4'b0011, 4'b0001, 4'b0001, 4'b0100);
        apply("sub_3_m1",     2'b00, 4'b0011, 4'b1111, 4'b0101, 4'b0000);
        apply("sub_4_2",      2'b00, 4'b0100, 4'b0010, 4'b0000, 4'b0000);
        apply("sub_7_2",      2'b00, 4'b0111, 4'b0010, 4'b0011, 4'b0000);
        apply("sub_dbl_ovf",  2'b00, 4'b0100, 4'b0110, 4'b0000, 4'b0011);
        apply("sub_diff_ovf", 2'b00, 4'b0111, 4'b1110, 4'b0000, 4'b0011);
        apply("sub_neg_ovf",  2'b00, 4'b1000, 4'b0001, 4'b0000, 4'b0011);
        apply("sub_min_ok",   2'b00, 4'b1010, 4'b0001, 4'b1000, 4'b0100);

        apply("lt_3_5",       2'b01, 4'd3,    4'd5,    4'b0001, 4'b0100);
        apply("lt_7_4",       2'b01, 4'd7,    4'd4,    4'b0000, 4'b0000);
        apply("lt_m4_3",      2'b01, 4'b1100, 4'd3,    4'b0001, 4'b0100);
        apply("lt_m3_m3",     2'b01, 4'b1101, 4'b1101, 4'b0000, 4'b0000);
        apply("lt_4_m5",      2'b01, 4'd4,    4'b1011, 4'b0000, 4'b0000);

        apply("clr_f_b2",     2'b10, 4'b1111, 4'b0010, 4'b1011, 4'b0100);
        apply("clr_f_b0",     2'b10, 4'b1111, 4'b0000, 4'b1110, 4'b0100);
        apply("clr_f_b3",     2'b10, 4'b1111, 4'b0011, 4'b0111, 4'b0100);
        apply("clr_b_eq_m",   2'b10, 4'b0101, 4'b0100, 4'b0000, 4'b0001);
        apply("clr_b_big",    2'b10, 4'b1111, 4'b1111, 4'b0000, 4'b0001);

        apply("sm_m5",        2'b11, 4'b1011, 4'b0110, 4'b1101, 4'b0100);
        apply("sm_zero",      2'b11, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        apply("sm_m7",        2'b11, 4'b1001, 4'b0000, 4'b1111, 4'b1000);
        apply("sm_3",         2'b11, 4'b0011, 4'b1010, 4'b0011, 4'b0000);
        apply("sm_m8",        2'b11, 4'b1000, 4'b0001, 4'b0000, 4'b0001);
        apply("sm_m1",        2'b11, 4'b1111, 4'b0000, 4'b1001, 4'b0000);

        apply("load_nonzero", 2'b10, 4'b1111, 4'b0001, 4'b1101, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 4'b0000, 4'b0000);
        @(negedge clk);
        op    = 2'b11;
        arg_a = 4'b0011;
        @(posedge clk);
        #1;
        check("reset_ignores_edge", 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_waits_edge", 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        check("first_edge_after_release", 4'b0011, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
